pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage RISC-V pipeline. It drives write-enables and flush/bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Resolves three hazard types:
  - load-use hazards, by inserting a one-cycle bubble;
  - taken branches resolved in MEM, by flushing three younger stages;
  - multi-cycle data-memory accesses, by a req/ready handshake that freezes the pipeline.
- Keeps saturating performance counters.
- Detects memory timeout with a sticky error.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 21 ++
 rtl/pipeline_hazard_ctrl_if.sv | 45 ++++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 22 ++
 rtl/pipeline_hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  localparam int unsigned WAIT_W = 16;
  localparam logic [4:0]  REG_X0 = 5'd0;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } pipe_state_e;

  typedef struct packed {
    logic write;
    logic flush;
  } stage_ctrl_t;

  localparam stage_ctrl_t STAGE_IDLE = '{write: 1'b0, flush: 1'b0};
  localparam stage_ctrl_t STAGE_ADV  = '{write: 1'b1, flush: 1'b0};

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard inputs, stage controls and status of the pipeline stall/flush sequencer.
interface pipeline_hazard_ctrl_if #(parameter int unsigned CNT_W = 32);

  logic [4:0]       ifid_rs1;
  logic [4:0]       ifid_rs2;
  logic [4:0]       idex_rd;
  logic             idex_memread;
  logic             exmem_branch;
  logic             exmem_zero;
  logic             exmem_memread;
  logic             exmem_memwrite;
  logic             dmem_ready;
  logic             dmem_req;
  logic             pc_write;
  logic             ifid_write;
  logic             idex_write;
  logic             exmem_write;
  logic             memwb_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             memwb_bubble;
  logic             pc_sel_branch;
  logic             mem_timeout;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport slave (
    input  ifid_rs1, ifid_rs2, idex_rd, idex_memread, exmem_branch, exmem_zero,
           exmem_memread, exmem_memwrite, dmem_ready,
    output dmem_req, pc_write, ifid_write, idex_write, exmem_write, memwb_write,
           ifid_flush, idex_flush, exmem_flush, memwb_bubble, pc_sel_branch,
           mem_timeout, state, stall_cycles, flush_events
  );

  modport master (
    output ifid_rs1, ifid_rs2, idex_rd, idex_memread, exmem_branch, exmem_zero,
           exmem_memread, exmem_memwrite, dmem_ready,
    input  dmem_req, pc_write, ifid_write, idex_write, exmem_write, memwb_write,
           ifid_flush, idex_flush, exmem_flush, memwb_bubble, pc_sel_branch,
           mem_timeout, state, stall_cycles, flush_events
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flushes,
// data-memory wait freezes with timeout, and saturating performance counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave bus
);

  pipe_state_e       state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_q, timeout_d;
  logic [WAIT_W:0]   wait_inc_c;

  stage_ctrl_t pc_c, ifid_c, idex_c, exmem_c, memwb_c;
  logic        req_c, flush_inc_c;
  logic        mem_op_c, taken_c, lu_c;

  assign mem_op_c   = bus.exmem_memread | bus.exmem_memwrite;
  assign taken_c    = bus.exmem_branch & bus.exmem_zero;
  assign lu_c       = bus.idex_memread && (bus.idex_rd != REG_X0) &&
                      ((bus.idex_rd == bus.ifid_rs1) || (bus.idex_rd == bus.ifid_rs2));
  assign wait_inc_c = {1'b0, wait_q} + (WAIT_W+1)'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  // Stage controls are combinational; pc_c.flush carries the branch-target select
  // and memwb_c.flush carries the MEM/WB bubble.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    timeout_d   = timeout_q;
    req_c       = 1'b0;
    flush_inc_c = 1'b0;
    pc_c        = STAGE_IDLE;
    ifid_c      = STAGE_IDLE;
    idex_c      = STAGE_IDLE;
    exmem_c     = STAGE_IDLE;
    memwb_c     = STAGE_IDLE;

    case (state_q)
      ST_RUN: begin
        if (mem_op_c) begin
          req_c = 1'b1;
          if (bus.dmem_ready) begin
            pc_c = STAGE_ADV; ifid_c = STAGE_ADV; idex_c = STAGE_ADV;
            exmem_c = STAGE_ADV; memwb_c = STAGE_ADV;
          end else begin
            memwb_c.flush = 1'b1;
            wait_d        = WAIT_W'(1);
            if (MEM_TIMEOUT <= 1) begin
              state_d   = ST_ERROR;
              timeout_d = 1'b1;
            end else begin
              state_d = ST_MEM_WAIT;
            end
          end
        end else if (taken_c) begin
          pc_c = '{write: 1'b1, flush: 1'b1};
          ifid_c = '{write: 1'b1, flush: 1'b1};
          idex_c = '{write: 1'b1, flush: 1'b1};
          exmem_c = '{write: 1'b1, flush: 1'b1};
          memwb_c = STAGE_ADV;
          flush_inc_c = 1'b1;
        end else if (lu_c) begin
          idex_c = '{write: 1'b1, flush: 1'b1};
          exmem_c = STAGE_ADV; memwb_c = STAGE_ADV;
        end else begin
          pc_c = STAGE_ADV; ifid_c = STAGE_ADV; idex_c = STAGE_ADV;
          exmem_c = STAGE_ADV; memwb_c = STAGE_ADV;
        end
      end
      ST_MEM_WAIT: begin
        req_c = 1'b1;
        if (bus.dmem_ready) begin
          pc_c = STAGE_ADV; ifid_c = STAGE_ADV; idex_c = STAGE_ADV;
          exmem_c = STAGE_ADV; memwb_c = STAGE_ADV;
          state_d = ST_RUN;
        end else begin
          memwb_c.flush = 1'b1;
          wait_d        = wait_inc_c[WAIT_W-1:0];
          if (wait_inc_c >= (WAIT_W+1)'(MEM_TIMEOUT)) begin
            state_d   = ST_ERROR;
            timeout_d = 1'b1;
          end
        end
      end
      ST_ERROR: begin
        memwb_c.flush = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (reset) begin
      req_c   = 1'b0;
      pc_c    = STAGE_IDLE;
      ifid_c  = STAGE_IDLE;
      idex_c  = STAGE_IDLE;
      exmem_c = STAGE_IDLE;
      memwb_c = STAGE_IDLE;
    end
  end

  assign bus.dmem_req      = req_c;
  assign bus.pc_write      = pc_c.write;
  assign bus.ifid_write    = ifid_c.write;
  assign bus.idex_write    = idex_c.write;
  assign bus.exmem_write   = exmem_c.write;
  assign bus.memwb_write   = memwb_c.write;
  assign bus.ifid_flush    = ifid_c.flush;
  assign bus.idex_flush    = idex_c.flush;
  assign bus.exmem_flush   = exmem_c.flush;
  assign bus.memwb_bubble  = memwb_c.flush;
  assign bus.pc_sel_branch = pc_c.flush;
  assign bus.mem_timeout   = timeout_q;
  assign bus.state         = state_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (~pc_c.write),
    .clear (1'b0),
    .count (bus.stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc_c),
    .clear (1'b0),
    .count (bus.flush_events)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed hazard scenarios then random traffic,
// two instances (wide and 3-bit counters) compared against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned TO = 4;

  // Control vector bit positions
  localparam logic [10:0] REQ   = 11'b100_0000_0000;
  localparam logic [10:0] PCW   = 11'b010_0000_0000;
  localparam logic [10:0] IFIDW = 11'b001_0000_0000;
  localparam logic [10:0] ALLW  = 11'b011_1110_0000;
  localparam logic [10:0] IFIDF = 11'b000_0001_0000;
  localparam logic [10:0] IDEXF = 11'b000_0000_1000;
  localparam logic [10:0] EXMF  = 11'b000_0000_0100;
  localparam logic [10:0] BUB   = 11'b000_0000_0010;
  localparam logic [10:0] SEL   = 11'b000_0000_0001;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1, rs2, rd;
  logic       ldx, br, zr, mrd, mwr, rdy;

  int checks = 0;
  int errors = 0;

  int     m_state;
  int     m_wait;
  longint m_stall;
  longint m_flush;
  bit     m_to;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(32)) if_a ();
  pipeline_hazard_ctrl_if #(.CNT_W(3))  if_b ();

  assign if_a.ifid_rs1 = rs1;       assign if_b.ifid_rs1 = rs1;
  assign if_a.ifid_rs2 = rs2;       assign if_b.ifid_rs2 = rs2;
  assign if_a.idex_rd = rd;         assign if_b.idex_rd = rd;
  assign if_a.idex_memread = ldx;   assign if_b.idex_memread = ldx;
  assign if_a.exmem_branch = br;    assign if_b.exmem_branch = br;
  assign if_a.exmem_zero = zr;      assign if_b.exmem_zero = zr;
  assign if_a.exmem_memread = mrd;  assign if_b.exmem_memread = mrd;
  assign if_a.exmem_memwrite = mwr; assign if_b.exmem_memwrite = mwr;
  assign if_a.dmem_ready = rdy;     assign if_b.dmem_ready = rdy;

  pipeline_hazard_ctrl #(.CNT_W(32), .MEM_TIMEOUT(TO)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
  pipeline_hazard_ctrl #(.CNT_W(3),  .MEM_TIMEOUT(TO)) dut_b (.clk(clk), .reset(reset), .bus(if_b));

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [10:0] obs_a();
    return {if_a.dmem_req, if_a.pc_write, if_a.ifid_write, if_a.idex_write, if_a.exmem_write,
            if_a.memwb_write, if_a.ifid_flush, if_a.idex_flush, if_a.exmem_flush,
            if_a.memwb_bubble, if_a.pc_sel_branch};
  endfunction

  function automatic logic [10:0] obs_b();
    return {if_b.dmem_req, if_b.pc_write, if_b.ifid_write, if_b.idex_write, if_b.exmem_write,
            if_b.memwb_write, if_b.ifid_flush, if_b.idex_flush, if_b.exmem_flush,
            if_b.memwb_bubble, if_b.pc_sel_branch};
  endfunction

  function automatic logic [63:0] sat3(input longint n);
    return (n > 7) ? 64'd7 : 64'(n);
  endfunction

  function automatic bit mem_op();
    return mrd || mwr;
  endfunction

  function automatic bit taken();
    return br && zr;
  endfunction

  function automatic bit load_use();
    return ldx && (rd != 0) && ((rd == rs1) || (rd == rs2));
  endfunction

  // Expected stage controls from the hazard rules for the current model state
  function automatic logic [10:0] model_ctrl();
    if (reset) return '0;
    if (m_state == 2) return BUB;
    if (m_state == 1) return rdy ? (ALLW | REQ) : (REQ | BUB);
    if (mem_op()) return rdy ? (ALLW | REQ) : (REQ | BUB);
    if (taken()) return ALLW | IFIDF | IDEXF | EXMF | SEL;
    if (load_use()) return (ALLW & ~(PCW | IFIDW)) | IDEXF;
    return ALLW;
  endfunction

  task automatic model_clear();
    m_state = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_to = 1'b0;
  endtask

  // One clock: compare everything, then advance the model across the edge
  task automatic tick();
    logic [10:0] e;
    if (reset) model_clear();
    e = model_ctrl();
    #2;
    chk("ctrl_a", 64'(obs_a()), 64'(e));
    chk("ctrl_b", 64'(obs_b()), 64'(e));
    chk("state", 64'(if_a.state), 64'(m_state));
    chk("timeout", 64'(if_a.mem_timeout), 64'(m_to));
    chk("stall_a", 64'(if_a.stall_cycles), 64'(m_stall));
    chk("flush_a", 64'(if_a.flush_events), 64'(m_flush));
    chk("stall_b", 64'(if_b.stall_cycles), sat3(m_stall));
    chk("flush_b", 64'(if_b.flush_events), sat3(m_flush));
    @(posedge clk);
    #1;
    if (reset) begin
      model_clear();
    end else begin
      if (!e[9]) m_stall++;
      if (m_state == 0 && !mem_op() && taken()) m_flush++;
      if (m_state == 0 && mem_op() && !rdy) begin
        m_wait = 1;
        if (m_wait >= TO) begin m_state = 2; m_to = 1'b1; end
        else m_state = 1;
      end else if (m_state == 1) begin
        if (rdy) m_state = 0;
        else begin
          m_wait++;
          if (m_wait >= TO) begin m_state = 2; m_to = 1'b1; end
        end
      end
    end
  endtask

  task automatic idle_inputs();
    rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3;
    ldx = 1'b0; br = 1'b0; zr = 1'b0; mrd = 1'b0; mwr = 1'b0; rdy = 1'b1;
  endtask

  initial begin
    model_clear();
    idle_inputs();
    reset = 1'b1;
    mrd = 1'b1; br = 1'b1; zr = 1'b1;
    #1;
    chk("reset_ctrl", 64'(obs_a()), 64'd0);
    tick();
    tick();
    chk("reset_state", 64'(if_a.state), 64'd0);
    chk("reset_stall", 64'(if_a.stall_cycles), 64'd0);
    idle_inputs();
    reset = 1'b0;
    tick();

    // Load-use on rs2: one bubble
    ldx = 1'b1; rd = 5'd5; rs1 = 5'd1; rs2 = 5'd5;
    #1;
    chk("lu_pc_write", 64'(if_a.pc_write), 64'd0);
    chk("lu_idex_flush", 64'(if_a.idex_flush), 64'd1);
    tick();
    ldx = 1'b0;
    tick();
    chk("lu_stall_cnt", 64'(if_a.stall_cycles), 64'd1);

    // Load into x0 never stalls
    ldx = 1'b1; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    #1;
    chk("x0_pc_write", 64'(if_a.pc_write), 64'd1);
    chk("x0_ifid_write", 64'(if_a.ifid_write), 64'd1);
    tick();

    // Taken branch wins over a simultaneous load-use
    ldx = 1'b1; rd = 5'd5; rs1 = 5'd5; br = 1'b1; zr = 1'b1;
    #1;
    chk("br_ctrl", 64'(obs_a()), 64'(ALLW | IFIDF | IDEXF | EXMF | SEL));
    tick();
    idle_inputs();
    chk("br_flush_cnt", 64'(if_a.flush_events), 64'd1);
    chk("br_stall_cnt", 64'(if_a.stall_cycles), 64'd1);

    // Three-cycle memory wait, then release
    mrd = 1'b1; rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mw_state", 64'(if_a.state), 64'd1);
    end
    rdy = 1'b1;
    #1;
    chk("mw_release", 64'(obs_a()), 64'(ALLW | REQ));
    tick();
    chk("mw_back_run", 64'(if_a.state), 64'd0);
    chk("mw_stall_cnt", 64'(if_a.stall_cycles), 64'd4);

    // Timeout after TO stalled cycles, sticky until reset
    mwr = 1'b1; mrd = 1'b0; rdy = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("to_not_yet", 64'(if_a.state), 64'd1);
    tick();
    chk("to_state", 64'(if_a.state), 64'd2);
    chk("to_flag", 64'(if_a.mem_timeout), 64'd1);
    rdy = 1'b1;
    tick();
    tick();
    chk("to_hold", 64'(if_a.state), 64'd2);
    reset = 1'b1;
    #1;
    chk("to_rst_state", 64'(if_a.state), 64'd0);
    chk("to_rst_flag", 64'(if_a.mem_timeout), 64'd0);
    chk("to_rst_stall", 64'(if_a.stall_cycles), 64'd0);
    model_clear();
    tick();
    reset = 1'b0;
    idle_inputs();

    // Ten load-use stalls saturate the 3-bit counter
    for (int i = 0; i < 10; i++) begin
      ldx = 1'b1; rd = 5'd7; rs1 = 5'd7;
      tick();
      ldx = 1'b0;
      tick();
    end
    chk("sat_stall_b", 64'(if_b.stall_cycles), 64'd7);
    chk("sat_stall_a", 64'(if_a.stall_cycles), 64'd10);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      if (m_state == 2) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom_range(0, 3));
      rd  = 5'($urandom_range(0, 3));
      ldx = 1'($urandom_range(0, 1));
      mrd = ($urandom_range(0, 3) == 0);
      mwr = !mrd && ($urandom_range(0, 5) == 0);
      br  = !(mrd || mwr) && ($urandom_range(0, 2) == 0);
      zr  = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
